// File: rtl/bmem_pkg.sv
// Shared types and sizing constants for the burst-memory arbiter.
package bmem_pkg;

    localparam int unsigned BEAT_WIDTH    = 64;
    localparam int unsigned BEATS         = 4;
    localparam int unsigned LINE_WIDTH    = BEAT_WIDTH * BEATS;
    localparam int unsigned LINE_OFFSET_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_CMD  = 3'd1,
        ST_RD_BEAT = 3'd2,
        ST_WR_BEAT = 3'd3,
        ST_WR_WAIT = 3'd4,
        ST_DONE    = 3'd5
    } bmem_arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } bmem_req_t;

endpackage

// File: rtl/bmem_line_buf.sv
// One cache line of storage: whole-line load for writebacks, beat-indexed
// load for read assembly, and a beat-indexed read port for serialization.
module bmem_line_buf
    import bmem_pkg::*;
#(
    parameter  int unsigned BEAT_WIDTH = bmem_pkg::BEAT_WIDTH,
    parameter  int unsigned BEATS      = bmem_pkg::BEATS,
    localparam int unsigned LINE_WIDTH = BEAT_WIDTH * BEATS,
    localparam int unsigned IDX_W      = $clog2(BEATS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  line_we,
    input  logic [LINE_WIDTH-1:0] line_wdata,
    input  logic                  beat_we,
    input  logic [IDX_W-1:0]      beat_idx,
    input  logic [BEAT_WIDTH-1:0] beat_wdata,
    output logic [LINE_WIDTH-1:0] line_rdata,
    output logic [BEAT_WIDTH-1:0] beat_rdata
);

    logic [LINE_WIDTH-1:0] line_q;
    logic [LINE_WIDTH-1:0] line_d;

    // Next line contents: full-line load wins over a single-beat update.
    always_comb begin
        line_d = line_q;
        if (line_we) begin
            line_d = line_wdata;
        end else if (beat_we) begin
            line_d[beat_idx*BEAT_WIDTH +: BEAT_WIDTH] = beat_wdata;
        end
    end

    // Line storage register.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign line_rdata = line_q;
    assign beat_rdata = line_q[beat_idx*BEAT_WIDTH +: BEAT_WIDTH];

endmodule

// File: rtl/bmem_arbiter.sv
// Arbitrates the I-cache and D-cache line requests onto a single 4-beat
// burst memory port, serializing writebacks and assembling read lines.
module bmem_arbiter
    import bmem_pkg::*;
#(
    parameter  int unsigned ADDR_WIDTH = 32,
    parameter  int unsigned BEAT_WIDTH = bmem_pkg::BEAT_WIDTH,
    parameter  int unsigned BEATS      = bmem_pkg::BEATS,
    localparam int unsigned LINE_WIDTH = BEAT_WIDTH * BEATS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_read,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic [ADDR_WIDTH-1:0] bmem_address,
    output logic                  bmem_read,
    output logic                  bmem_write,
    output logic [BEAT_WIDTH-1:0] bmem_wdata,
    input  logic [BEAT_WIDTH-1:0] bmem_rdata,
    input  logic                  bmem_resp
);

    localparam int unsigned OFF_W = $clog2(LINE_WIDTH / 8);
    localparam int unsigned CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

    bmem_arb_state_t       state_q, state_d;
    bmem_req_t             gnt_q, gnt_d;
    bmem_req_t             last_q, last_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [LINE_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_WIDTH-1:0] d_rdata_q, d_rdata_d;

    logic                  i_req, d_req;
    bmem_req_t             pick;
    logic [ADDR_WIDTH-1:0] pick_addr;
    logic                  buf_line_we, buf_beat_we;
    logic [LINE_WIDTH-1:0] buf_line;
    logic [BEAT_WIDTH-1:0] buf_beat;
    logic [LINE_WIDTH-1:0] assembled;

    bmem_line_buf #(
        .BEAT_WIDTH (BEAT_WIDTH),
        .BEATS      (BEATS)
    ) u_line_buf (
        .clk        (clk),
        .rst        (rst),
        .line_we    (buf_line_we),
        .line_wdata (d_wdata),
        .beat_we    (buf_beat_we),
        .beat_idx   (cnt_q),
        .beat_wdata (bmem_rdata),
        .line_rdata (buf_line),
        .beat_rdata (buf_beat)
    );

    // Grant selection, transfer sequencing and beat counting.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        buf_line_we = 1'b0;
        buf_beat_we = 1'b0;

        i_req     = i_read;
        d_req     = d_read | d_write;
        pick      = (i_req && d_req) ? ((last_q == REQ_I) ? REQ_D : REQ_I)
                                     : (d_req ? REQ_D : REQ_I);
        pick_addr = (pick == REQ_D) ? d_addr : i_addr;

        // The last beat lands in the buffer on the same edge that enters
        // DONE, so the returned line is built with that beat spliced in.
        assembled = buf_line;
        assembled[cnt_q*BEAT_WIDTH +: BEAT_WIDTH] = bmem_rdata;

        unique case (state_q)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    gnt_d  = pick;
                    last_d = pick;
                    addr_d = {pick_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                    cnt_d  = '0;
                    if (pick == REQ_D && d_write) begin
                        buf_line_we = 1'b1;
                        state_d     = ST_WR_BEAT;
                    end else begin
                        state_d = ST_RD_CMD;
                    end
                end
            end
            ST_RD_CMD: begin
                cnt_d   = '0;
                state_d = ST_RD_BEAT;
            end
            ST_RD_BEAT: begin
                if (bmem_resp) begin
                    buf_beat_we = 1'b1;
                    cnt_d       = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_DONE;
                        if (gnt_q == REQ_I) begin
                            i_rdata_d = assembled;
                        end else begin
                            d_rdata_d = assembled;
                        end
                    end
                end
            end
            ST_WR_BEAT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_WR_WAIT;
                end
            end
            ST_WR_WAIT: begin
                if (bmem_resp) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= REQ_I;
            last_q    <= REQ_I;
            addr_q    <= '0;
            cnt_q     <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign bmem_read    = (state_q == ST_RD_CMD);
    assign bmem_write   = (state_q == ST_WR_BEAT);
    assign bmem_wdata   = bmem_write ? buf_beat : '0;
    assign bmem_address = (state_q != ST_IDLE) ? addr_q : '0;
    assign i_resp       = (state_q == ST_DONE) && (gnt_q == REQ_I);
    assign d_resp       = (state_q == ST_DONE) && (gnt_q == REQ_D);
    assign i_rdata      = i_rdata_q;
    assign d_rdata      = d_rdata_q;

endmodule

// File: tb/tb_bmem_arbiter.sv
// Self-checking bench for bmem_arbiter: a memory responder driven per test,
// with expected completions queued and compared as responses appear.
module tb_bmem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  i_addr, d_addr;
    logic         i_read, d_read, d_write;
    logic [255:0] i_rdata, d_rdata, d_wdata;
    logic         i_resp, d_resp;
    logic [31:0]  bmem_address;
    logic         bmem_read, bmem_write;
    logic [63:0]  bmem_wdata, bmem_rdata;
    logic         bmem_resp;

    typedef struct {
        bit           side;   // 0 = I, 1 = D
        logic [255:0] line;
    } exp_t;

    exp_t         sb[$];
    logic [255:0] i_model, d_model;
    int           n_checks = 0;
    int           n_fail   = 0;

    always #5 clk = ~clk;

    bmem_arbiter #(.ADDR_WIDTH(32), .BEAT_WIDTH(64), .BEATS(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_addr       (i_addr),
        .i_read       (i_read),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_addr       (d_addr),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .bmem_address (bmem_address),
        .bmem_read    (bmem_read),
        .bmem_write   (bmem_write),
        .bmem_wdata   (bmem_wdata),
        .bmem_rdata   (bmem_rdata),
        .bmem_resp    (bmem_resp)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Memory side: return 4 beats of 'line', with bmem_resp following 'pat'
    // bit by bit for the first 'npat' cycles; counts cycles with a resp seen
    // before the last beat was delivered.
    task automatic serve_beats(input logic [255:0] line, input logic [15:0] pat,
                               input int npat, output int early);
        int  got;
        int  c;
        bit  valid;
        got   = 0;
        c     = 0;
        early = 0;
        while (got < 4 && c < 32) begin
            valid      = (c < npat) ? pat[c] : 1'b1;
            bmem_resp  = valid;
            bmem_rdata = valid ? line[got*64 +: 64] : {$urandom, $urandom};
            if (i_resp || d_resp) early++;
            tick();
            if (valid) got++;
            c++;
        end
        bmem_resp  = 1'b0;
        bmem_rdata = '0;
    endtask

    // Bounded wait for a completion pulse on either side.
    task automatic wait_resp(output bit ok, output bit side,
                             output logic [255:0] data, output int waited);
        ok     = 0;
        side   = 0;
        data   = '0;
        waited = 0;
        while (waited < 40) begin
            if (i_resp || d_resp) begin
                ok   = 1;
                side = d_resp;
                data = d_resp ? d_rdata : i_rdata;
                break;
            end
            tick();
            waited++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({bmem_read, bmem_write, i_resp, d_resp} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000", {bmem_read, bmem_write, i_resp, d_resp});
        end
        n_checks++;
        if (bmem_address !== 32'h0 || bmem_wdata !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_bus: addr %h wdata %h expected 0", bmem_address, bmem_wdata);
        end
        n_checks++;
        if (i_rdata !== '0 || d_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_rdata: i %h d %h expected 0", i_rdata, d_rdata);
        end
        i_model = '0;
        d_model = '0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_iread();
        logic [255:0] line, data;
        bit ok, side;
        int early, w;
        line   = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        i_addr = 32'h0000_1234;
        i_read = 1'b1;
        tick();
        n_checks++;
        if (bmem_read !== 1'b1 || bmem_address !== 32'h0000_1220) begin
            n_fail++;
            $display("FAIL iread_cmd: read %b addr %h expected 1 00001220", bmem_read, bmem_address);
        end
        tick();
        n_checks++;
        if (bmem_read !== 1'b0) begin
            n_fail++;
            $display("FAIL iread_cmd_pulse: read %b expected 0", bmem_read);
        end
        sb.push_back('{side: 1'b0, line: line});
        i_model = line;
        serve_beats(line, 16'hFFFF, 0, early);
        n_checks++;
        if (early != 0) begin
            n_fail++;
            $display("FAIL iread_early: got %0d early resp cycles expected 0", early);
        end
        wait_resp(ok, side, data, w);
        n_checks++;
        if (!ok || w != 0) begin
            n_fail++;
            $display("FAIL iread_latency: ok %0d waited %0d expected 1 0", ok, w);
        end
        if (ok) begin
            exp_t e = sb.pop_front();
            n_checks++;
            if (side !== e.side || data !== e.line) begin
                n_fail++;
                $display("FAIL iread_line: side %0d data %h expected %0d %h", side, data, e.side, e.line);
            end
        end
        n_checks++;
        if (d_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL iread_dresp: got %b expected 0", d_resp);
        end
        i_read = 1'b0;
        tick();
    endtask

    task automatic test_dwrite();
        logic [255:0] line, data;
        bit ok, side;
        int w;
        line    = {64'hDEAD_3333_3333_3333, 64'h2222_0000_2222_0000,
                   64'h1111_0000_1111_0000, 64'h0000_0000_0000_BEEF};
        d_addr  = 32'h8000_0040;
        d_wdata = line;
        d_write = 1'b1;
        tick();
        d_wdata = ~line;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (bmem_write !== 1'b1 || bmem_wdata !== line[k*64 +: 64] || bmem_address !== 32'h8000_0040) begin
                n_fail++;
                $display("FAIL dwrite_beat%0d: wr %b data %h addr %h expected 1 %h 80000040",
                         k, bmem_write, bmem_wdata, bmem_address, line[k*64 +: 64]);
            end
            tick();
        end
        n_checks++;
        if (bmem_write !== 1'b0 || d_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL dwrite_wait: wr %b resp %b expected 0 0", bmem_write, d_resp);
        end
        tick();
        tick();
        bmem_resp = 1'b1;
        sb.push_back('{side: 1'b1, line: d_model});
        tick();
        bmem_resp = 1'b0;
        wait_resp(ok, side, data, w);
        n_checks++;
        if (!ok || w != 0) begin
            n_fail++;
            $display("FAIL dwrite_latency: ok %0d waited %0d expected 1 0", ok, w);
        end
        if (ok) begin
            exp_t e = sb.pop_front();
            n_checks++;
            if (side !== e.side || data !== e.line) begin
                n_fail++;
                $display("FAIL dwrite_resp: side %0d data %h expected %0d %h", side, data, e.side, e.line);
            end
        end
        d_write = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        logic [255:0] line, data;
        logic [31:0]  exp_addr [3];
        bit           exp_side [3];
        bit ok, side;
        int early, w;
        exp_addr = '{32'h0000_3000, 32'h0000_2000, 32'h0000_3020};
        exp_side = '{1'b1, 1'b0, 1'b1};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        i_model = '0;
        d_model = '0;
        i_addr  = 32'h0000_2004;
        d_addr  = 32'h0000_3008;
        i_read  = 1'b1;
        d_read  = 1'b1;
        for (int t = 0; t < 3; t++) begin
            tick();
            n_checks++;
            if (bmem_read !== 1'b1 || bmem_address !== exp_addr[t]) begin
                n_fail++;
                $display("FAIL contend_grant%0d: read %b addr %h expected 1 %h", t, bmem_read, bmem_address, exp_addr[t]);
            end
            tick();
            line = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            sb.push_back('{side: exp_side[t], line: line});
            if (exp_side[t]) d_model = line; else i_model = line;
            serve_beats(line, 16'hFFFF, 0, early);
            wait_resp(ok, side, data, w);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL contend_timeout%0d: no resp expected one", t);
            end else begin
                exp_t e = sb.pop_front();
                n_checks++;
                if (side !== e.side || data !== e.line) begin
                    n_fail++;
                    $display("FAIL contend_line%0d: side %0d data %h expected %0d %h", t, side, data, e.side, e.line);
                end
            end
            // The served side drops for a cycle, then both contend again.
            if (side) d_read = 1'b0; else i_read = 1'b0;
            tick();
            d_addr = 32'h0000_3020;
            i_read = 1'b1;
            d_read = 1'b1;
        end
        i_read = 1'b0;
        d_read = 1'b0;
        tick();
        tick();
        n_checks++;
        if (i_rdata !== i_model || d_rdata !== d_model) begin
            n_fail++;
            $display("FAIL contend_hold: i %h d %h expected %h %h", i_rdata, d_rdata, i_model, d_model);
        end
    endtask

    task automatic test_gaps();
        logic [255:0] line, data;
        bit ok, side;
        int early, w;
        line   = {64'hA4A4_0000_0000_0004, 64'hA3A3_0000_0000_0003,
                  64'hA2A2_0000_0000_0002, 64'hA1A1_0000_0000_0001};
        i_addr = 32'h0000_5010;
        i_read = 1'b1;
        tick();
        tick();
        sb.push_back('{side: 1'b0, line: line});
        i_model = line;
        serve_beats(line, 16'b1011001, 7, early);
        n_checks++;
        if (early != 0) begin
            n_fail++;
            $display("FAIL gaps_early: got %0d early resp cycles expected 0", early);
        end
        wait_resp(ok, side, data, w);
        n_checks++;
        if (!ok || w != 0) begin
            n_fail++;
            $display("FAIL gaps_latency: ok %0d waited %0d expected 1 0", ok, w);
        end
        if (ok) begin
            exp_t e = sb.pop_front();
            n_checks++;
            if (side !== e.side || data !== e.line) begin
                n_fail++;
                $display("FAIL gaps_line: side %0d data %h expected %0d %h", side, data, e.side, e.line);
            end
        end
        i_read = 1'b0;
        tick();
    endtask

    task automatic test_hold_past_resp();
        logic [255:0] line, data;
        bit ok, side;
        int early, w, bad;
        line   = {64'h0D0D, 64'h0C0C, 64'h0B0B, 64'h0A0A};
        i_addr = 32'h0000_6000;
        i_read = 1'b1;
        tick();
        tick();
        sb.push_back('{side: 1'b0, line: line});
        i_model = line;
        serve_beats(line, 16'hFFFF, 0, early);
        wait_resp(ok, side, data, w);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL hold_timeout: no resp expected one");
        end else begin
            exp_t e = sb.pop_front();
            n_checks++;
            if (side !== e.side || data !== e.line) begin
                n_fail++;
                $display("FAIL hold_line: side %0d data %h expected %0d %h", side, data, e.side, e.line);
            end
        end
        tick();
        i_read    = 1'b0;
        bmem_resp = 1'b1;
        bad       = 0;
        for (int k = 0; k < 4; k++) begin
            if (bmem_read || bmem_write || i_resp || d_resp) bad++;
            tick();
            bmem_resp = 1'b0;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold_regrant: got %0d active cycles expected 0", bad);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [255:0] line, data;
        bit ok, side;
        int early, w, bad;
        line    = {64'h7777_0000_0000_0003, 64'h7777_0000_0000_0002,
                   64'h7777_0000_0000_0001, 64'h7777_0000_0000_0000};
        d_addr  = 32'h0000_9000;
        d_wdata = line;
        d_write = 1'b1;
        tick();
        tick();
        tick();
        n_checks++;
        if (bmem_write !== 1'b1 || bmem_wdata !== line[128 +: 64]) begin
            n_fail++;
            $display("FAIL rstw_beat2: wr %b data %h expected 1 %h", bmem_write, bmem_wdata, line[128 +: 64]);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (bmem_write !== 1'b0 || bmem_address !== 32'h0 || d_resp !== 1'b0 || i_rdata !== '0) begin
            n_fail++;
            $display("FAIL rstw_abort: wr %b addr %h resp %b irdata %h expected 0 0 0 0",
                     bmem_write, bmem_address, d_resp, i_rdata);
        end
        rst     = 1'b0;
        d_write = 1'b0;
        i_model = '0;
        d_model = '0;
        bad     = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bmem_write || bmem_read || i_resp || d_resp) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rstw_quiet: got %0d active cycles expected 0", bad);
        end
        line   = {64'hF00D_0000_0000_0004, 64'hF00D_0000_0000_0003,
                  64'hF00D_0000_0000_0002, 64'hF00D_0000_0000_0001};
        i_addr = 32'h0000_4008;
        i_read = 1'b1;
        tick();
        n_checks++;
        if (bmem_read !== 1'b1 || bmem_address !== 32'h0000_4000) begin
            n_fail++;
            $display("FAIL rstw_fresh_cmd: read %b addr %h expected 1 00004000", bmem_read, bmem_address);
        end
        tick();
        sb.push_back('{side: 1'b0, line: line});
        i_model = line;
        serve_beats(line, 16'hFFFF, 0, early);
        wait_resp(ok, side, data, w);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rstw_fresh_timeout: no resp expected one");
        end else begin
            exp_t e = sb.pop_front();
            n_checks++;
            if (side !== e.side || data !== e.line) begin
                n_fail++;
                $display("FAIL rstw_fresh_line: side %0d data %h expected %0d %h", side, data, e.side, e.line);
            end
        end
        i_read = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        i_addr     = '0;
        d_addr     = '0;
        i_read     = 1'b0;
        d_read     = 1'b0;
        d_write    = 1'b0;
        d_wdata    = '0;
        bmem_rdata = '0;
        bmem_resp  = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_iread();
        test_dwrite();
        test_contention();
        test_gaps();
        test_hold_past_resp();
        test_reset_mid_write();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bmem_arbiter.md
# bmem_arbiter

Shares the single burst-memory port of `mp4` between the instruction cache and the data cache. It accepts whole-cache-line requests (256 bits) from each cache and chooses one requester at a time. It then serializes the chosen request into a 4-beat, 64-bit burst on the `bmem_*` interface and reassembles read beats into a line for the requester. It sits between the cache pair and the top-level `bmem_*` ports of `mp4`.

## Interface
- `ADDR_WIDTH`, 32, byte address width
- `BEAT_WIDTH`, 64, bits per burst beat
- `BEATS`, 4, beats per line; `LINE_WIDTH` = `BEAT_WIDTH*BEATS` = 256 (derived, not overridable)

Ports:
- `clk`  in  1  sole clock
- `rst`  in  1  synchronous, active-high reset
- `i_addr`  in  ADDR_WIDTH  I-side line address
- `i_read`  in  1  I-side read request (level)
- `i_rdata`  out  LINE_WIDTH  I-side returned line
- `i_resp`  out  1  I-side completion pulse
- `d_addr`  in  ADDR_WIDTH  D-side line address
- `d_read`  in  1  D-side read request (level)
- `d_write`  in  1  D-side writeback request (level); never asserted together with `d_read`
- `d_wdata`  in  LINE_WIDTH  D-side writeback line
- `d_rdata`  out  LINE_WIDTH  D-side returned line
- `d_resp`  out  1  D-side completion pulse
- `bmem_address`  out  ADDR_WIDTH  burst address, low 5 bits forced to 0
- `bmem_read`  out  1  burst read command, one cycle
- `bmem_write`  out  1  burst write beat strobe
- `bmem_wdata`  out  BEAT_WIDTH  write beat data
- `bmem_rdata`  in  BEAT_WIDTH  read beat data
- `bmem_resp`  in  1  read beat valid / write done

## Operation
- States:
  - IDLE: evaluates requests.
  - RD_CMD: `bmem_read`=1 for exactly one cycle, `bmem_address` valid.
  - RD_BEAT: captures beats.
  - WR_BEAT: drives the 4 beats.
  - WR_WAIT: waits for write acknowledge.
  - DONE: pulses resp.
- Arbitration in IDLE:
  - If only one side requests, it is granted.
  - If both request, the side not granted last is granted.
  - The last-granted pointer resets to I, so D wins the first contention.
  - The grant, the address (low 5 bits cleared) and, for writes, the line are latched on the grant edge.
  - D-side read → RD_CMD; D-side write → WR_BEAT; I-side read → RD_CMD.
- Read transfer:
  - In RD_BEAT, each cycle with `bmem_resp`=1 stores `bmem_rdata` into beat slot `cnt`. Beat 0 occupies line bits [63:0]; beat k occupies [64k+63:64k].
  - Beats may be non-consecutive; cycles with `bmem_resp`=0 are ignored.
  - After beat 3 → DONE.
- Write transfer:
  - WR_BEAT drives `bmem_write`=1 for 4 consecutive cycles, with `bmem_wdata` = latched beat `cnt`, beat 0 first.
  - `bmem_address` is held throughout the beats. Then WR_WAIT until `bmem_resp`=1 → DONE.
- Beat counter: 2-bit, cleared on entering RD_BEAT or WR_BEAT, wraps 3→0 only on state exit.
- DONE:
  - The granted side's `*_resp`=1 for one cycle.
  - The granted side's `*_rdata` holds the assembled line; reads only, write responses leave rdata unchanged.
  - Next state is IDLE.
- Requester rule: a requester deasserts its request in the cycle after its resp. The arbiter ignores all requests during DONE, so a still-high request is not re-granted spuriously.
- `bmem_address` is driven only while a transfer is active; it is 0 in IDLE.

## Timing
- Reset values:
  - State IDLE; `bmem_read`, `bmem_write`, `i_resp`, `d_resp` = 0.
  - `bmem_address`, `bmem_wdata` = 0; `i_rdata`, `d_rdata` = 0.
  - Last-grant pointer = I; counter = 0.
- Request-to-command latency:
  - A request seen high in IDLE at edge N gives `bmem_read` high during cycle N+1.
  - For writes, it gives the first `bmem_write` beat during cycle N+1.
- Read latency: the final beat captured at edge M gives resp high during cycle M+1.
- Write latency: `bmem_resp` at edge M gives resp during cycle M+1.
- Minimum back-to-back spacing is one IDLE cycle between transactions.
- Reset mid-transfer: returns to IDLE next edge with all outputs at reset values. The partial burst is abandoned; the bench resets memory concurrently.
- `bmem_resp` outside RD_BEAT or WR_WAIT is ignored.

## Structure
- Shared package `bmem_pkg`:
  - state enum `bmem_arb_state_t`.
  - `BEAT_WIDTH`, `BEATS`, `LINE_WIDTH` and the line-offset width (5).
  - requester enum `bmem_req_t` {REQ_I, REQ_D}.
- Optional sub-module `bmem_line_buf`: 256-bit line register with beat-indexed write and beat-indexed read mux. Shared by the read assembly and write serialization paths.

## Test plan
- Single I-read at 0x0000_1234:
  - `bmem_address`=0x0000_1220 with one-cycle `bmem_read`.
  - Beats 0x11..,0x22..,0x33..,0x44.. → `i_rdata`={beat3,beat2,beat1,beat0}, `i_resp` one cycle after beat 3, `d_resp` stays 0.
- D-writeback of line 0xDEAD..BEEF to 0x8000_0040:
  - 4 consecutive `bmem_write` beats in low-to-high order, address held.
  - `bmem_resp` 3 cycles later → `d_resp` next cycle.
- Simultaneous I-read and D-read out of reset:
  - D served first, then I.
  - Repeat with both held high again → alternation I, D.
- Read beats with gaps (`bmem_resp` pattern 1,0,0,1,1,0,1) → line assembled correctly; resp only after the 4th valid beat.
- Requester holds request one cycle past resp → no second `bmem_read` issued from the DONE cycle.
- `rst` asserted during beat 2 of a write:
  - `bmem_write` 0 the next cycle; no resp is issued.
  - A fresh I-read afterwards completes normally.
